// File: rtl/core_ex_regfile_mp.sv
// Multi-port execute-stage integer register file with optional write-to-read bypass
// and a per-register busy scoreboard for RAW hazard stalls; x0 is hard-wired zero.
module core_ex_regfile_mp #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RF_NUM  = 32,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD*RFIDX_W-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0]      rd_dat,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wb_wen,
    input  logic [NWR*RFIDX_W-1:0]   wb_idx,
    input  logic [NWR*XLEN-1:0]      wb_dat,
    input  logic [NWR-1:0]           wb_clr,
    input  logic                     sb_set,
    input  logic [RFIDX_W-1:0]       sb_idx,
    output logic                     sb_busy_any
);

    logic [XLEN-1:0]    regs_q [RF_NUM];
    logic [XLEN-1:0]    regs_d [RF_NUM];
    logic [RF_NUM-1:0]  busy_q;
    logic [RF_NUM-1:0]  busy_d;
    logic [RFIDX_W-1:0] widx;
    logic [RFIDX_W-1:0] ridx;

    // Next state: ascending port order lets the highest port win a write conflict,
    // and the set is applied after clears so a fresh producer keeps the bit busy.
    always_comb begin : next_state
        regs_d = regs_q;
        busy_d = busy_q;
        widx   = '0;
        for (int p = 0; p < int'(NWR); p++) begin
            widx = wb_idx[p*RFIDX_W +: RFIDX_W];
            if (wb_wen[p] && (widx != '0)) begin
                regs_d[widx] = wb_dat[p*XLEN +: XLEN];
            end
            if (wb_wen[p] && wb_clr[p]) begin
                busy_d[widx] = 1'b0;
            end
        end
        if (sb_set) begin
            busy_d[sb_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Per-register enabled flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin : state_regs
        if (!rst_n) begin
            for (int i = 0; i < int'(RF_NUM); i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < int'(RF_NUM); i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read; a value being retired this cycle is forwarded, so it is no hazard.
    always_comb begin : read_ports
        rd_dat  = '0;
        rd_busy = '0;
        ridx    = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            ridx = rd_idx[k*RFIDX_W +: RFIDX_W];
            rd_dat[k*XLEN +: XLEN] = regs_q[ridx];
            rd_busy[k]             = busy_q[ridx];
            if (BYPASS != 0) begin
                for (int p = 0; p < int'(NWR); p++) begin
                    if (wb_wen[p] && (wb_idx[p*RFIDX_W +: RFIDX_W] == ridx)) begin
                        rd_dat[k*XLEN +: XLEN] = wb_dat[p*XLEN +: XLEN];
                        if (wb_clr[p]) begin
                            rd_busy[k] = 1'b0;
                        end
                    end
                end
            end
            if (ridx == '0) begin
                rd_dat[k*XLEN +: XLEN] = '0;
                rd_busy[k]             = 1'b0;
            end
        end
    end

    assign sb_busy_any = |busy_q;

endmodule

// File: tb/tb_core_ex_regfile_mp.sv
// Bench for core_ex_regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are checked every cycle against an architectural model, plus literal expectations.
module tb_core_ex_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_idx;
    logic [63:0] rd_dat_b, rd_dat_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [1:0]  wb_wen;
    logic [9:0]  wb_idx;
    logic [63:0] wb_dat;
    logic [1:0]  wb_clr;
    logic        sb_set;
    logic [4:0]  sb_idx;
    logic        any_b, any_n;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [31:0] model_regs [32];
    bit          model_busy [32];

    always #5 clk = ~clk;

    core_ex_regfile_mp #(.XLEN(32), .RF_NUM(32), .RFIDX_W(5), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_dat(rd_dat_b), .rd_busy(rd_busy_b),
        .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_dat(wb_dat), .wb_clr(wb_clr),
        .sb_set(sb_set), .sb_idx(sb_idx), .sb_busy_any(any_b));

    core_ex_regfile_mp #(.XLEN(32), .RF_NUM(32), .RFIDX_W(5), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_dat(rd_dat_n), .rd_busy(rd_busy_n),
        .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_dat(wb_dat), .wb_clr(wb_clr),
        .sb_set(sb_set), .sb_idx(sb_idx), .sb_busy_any(any_n));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: writes in port order, clears, then set; reset wipes everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                model_regs[i] = '0;
                model_busy[i] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wb_wen[p] && wb_idx[p*5 +: 5] != 5'd0) model_regs[wb_idx[p*5 +: 5]] = wb_dat[p*32 +: 32];
            end
            for (int p = 0; p < 2; p++) begin
                if (wb_wen[p] && wb_clr[p]) model_busy[wb_idx[p*5 +: 5]] = 1'b0;
            end
            if (sb_set && sb_idx != 5'd0) model_busy[sb_idx] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_dat(input int k, input bit byp);
        int idx;
        logic [31:0] v;
        idx = int'(rd_idx[k*5 +: 5]);
        v = model_regs[idx];
        if (byp) begin
            for (int p = 0; p < 2; p++) begin
                if (wb_wen[p] && int'(wb_idx[p*5 +: 5]) == idx) v = wb_dat[p*32 +: 32];
            end
        end
        if (idx == 0) v = '0;
        return v;
    endfunction

    function automatic bit exp_busy(input int k, input bit byp);
        int idx;
        bit b;
        idx = int'(rd_idx[k*5 +: 5]);
        b = (idx != 0) && model_busy[idx];
        if (byp) begin
            for (int p = 0; p < 2; p++) begin
                if (wb_wen[p] && wb_clr[p] && int'(wb_idx[p*5 +: 5]) == idx) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic bit exp_any();
        bit a = 1'b0;
        for (int i = 0; i < 32; i++) a = a | model_busy[i];
        return a;
    endfunction

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cmp_dat_b%0d", k), rd_dat_b[k*32 +: 32], exp_dat(k, 1'b1));
                chk($sformatf("cmp_dat_n%0d", k), rd_dat_n[k*32 +: 32], exp_dat(k, 1'b0));
                chk($sformatf("cmp_busy_b%0d", k), 32'(rd_busy_b[k]), 32'(exp_busy(k, 1'b1)));
                chk($sformatf("cmp_busy_n%0d", k), 32'(rd_busy_n[k]), 32'(exp_busy(k, 1'b0)));
            end
            chk("cmp_any_b", 32'(any_b), 32'(exp_any()));
            chk("cmp_any_n", 32'(any_n), 32'(exp_any()));
        end
    end

    task automatic idle();
        wb_wen = '0; wb_idx = '0; wb_dat = '0; wb_clr = '0; sb_set = 1'b0; sb_idx = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int p, input int idx, input logic [31:0] d, input bit clr);
        wb_wen[p] = 1'b1;
        wb_idx[p*5 +: 5] = 5'(idx);
        wb_dat[p*32 +: 32] = d;
        wb_clr[p] = clr;
    endtask

    task automatic rd(input int i0, input int i1);
        rd_idx = {5'(i1), 5'(i0)};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        rd(0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;

        // Reset state
        rd(5, 3);
        @(negedge clk);
        chk("rst_dat", rd_dat_b[31:0], 32'h0);
        chk("rst_busy", 32'(rd_busy_b), 32'h0);
        chk("rst_any", 32'(any_b), 32'h0);

        // Basic write/read, bypass vs none
        next(); wr(0, 3, 32'h12345678, 1'b0); rd(3, 0);
        @(negedge clk);
        chk("wr3_byp_same", rd_dat_b[31:0], 32'h12345678);
        chk("wr3_nobyp_same", rd_dat_n[31:0], 32'h0);
        next(); rd(3, 0);
        @(negedge clk);
        chk("wr3_nobyp_next", rd_dat_n[31:0], 32'h12345678);
        chk("model_x3", model_regs[3], 32'h12345678);

        // x0 ignores writes
        next(); wr(0, 0, 32'hFFFFFFFF, 1'b0); rd(0, 0);
        @(negedge clk);
        chk("x0_byp", rd_dat_b[31:0], 32'h0);
        next(); rd(0, 0);
        @(negedge clk);
        chk("x0_next", rd_dat_n[31:0], 32'h0);

        // Bypass on read port 1
        next(); wr(0, 7, 32'hA5A5A5A5, 1'b0); rd(3, 7);
        @(negedge clk);
        chk("x7_byp_p1", rd_dat_b[63:32], 32'hA5A5A5A5);
        chk("x7_nobyp_old", rd_dat_n[63:32], 32'h0);
        next(); rd(3, 7);
        @(negedge clk);
        chk("x7_nobyp_new", rd_dat_n[63:32], 32'hA5A5A5A5);

        // Write/write conflict: port 1 wins
        next(); wr(0, 9, 32'h1111, 1'b0); wr(1, 9, 32'h2222, 1'b0); rd(9, 7);
        @(negedge clk);
        chk("conf_byp", rd_dat_b[31:0], 32'h2222);
        next(); rd(9, 9);
        @(negedge clk);
        chk("conf_reg_b", rd_dat_b[31:0], 32'h2222);
        chk("conf_reg_n", rd_dat_n[63:32], 32'h2222);

        // Scoreboard set then retire
        next(); sb_set = 1'b1; sb_idx = 5'd4; rd(4, 0);
        @(negedge clk);
        chk("sb_set_same", 32'(rd_busy_b[0]), 32'h0);
        next(); rd(4, 0);
        @(negedge clk);
        chk("sb_set_next", 32'(rd_busy_b[0]), 32'h1);
        chk("sb_any_set", 32'(any_b), 32'h1);
        next(); wr(0, 4, 32'h00000044, 1'b1); rd(4, 4);
        @(negedge clk);
        chk("sb_clr_byp", 32'(rd_busy_b[0]), 32'h0);
        chk("sb_clr_nobyp", 32'(rd_busy_n[1]), 32'h1);
        next(); rd(4, 4);
        @(negedge clk);
        chk("sb_clr_next", 32'(rd_busy_n[0]), 32'h0);
        chk("sb_any_clr", 32'(any_b), 32'h0);

        // Set/clear collision on the same register
        next(); sb_set = 1'b1; sb_idx = 5'd4; rd(4, 0);
        next(); sb_set = 1'b1; sb_idx = 5'd4; wr(0, 4, 32'h4444, 1'b1); rd(4, 0);
        @(negedge clk);
        chk("coll_same_b", 32'(rd_busy_b[0]), 32'h0);
        chk("coll_same_n", 32'(rd_busy_n[0]), 32'h1);
        next(); sb_set = 1'b1; sb_idx = 5'd0; rd(4, 0);
        @(negedge clk);
        chk("coll_busy", 32'(rd_busy_b[0]), 32'h1);
        chk("coll_dat", rd_dat_n[31:0], 32'h4444);
        next(); wb_clr = 2'b01; wb_idx = 10'd4; rd(4, 0);
        @(negedge clk);
        chk("set0_busy0", 32'(rd_busy_b[1]), 32'h0);
        chk("set0_any", 32'(any_n), 32'h1);
        next(); rd(4, 0);
        @(negedge clk);
        chk("clr_nowen_ign", 32'(rd_busy_n[0]), 32'h1);
        next(); wr(1, 4, 32'h4445, 1'b1); rd(4, 0);
        next(); rd(4, 0);
        @(negedge clk);
        chk("coll_final_any", 32'(any_b), 32'h0);

        // Directed sweep over many indices with mixed set/clear/conflict traffic
        for (int i = 1; i < 32; i++) begin
            next();
            wr(0, i, 32'(i) * 32'h01010101, (i % 5) == 0);
            if (i % 3 == 0) wr(1, 32 - i, 32'hC0DE0000 | 32'(i), (i % 2) == 0);
            if (i % 4 == 0) begin sb_set = 1'b1; sb_idx = 5'(i + 1); end
            rd(i, i - 1);
        end
        for (int i = 0; i < 32; i++) begin
            next(); rd(i, 31 - i);
        end

        // Asynchronous reset mid-run
        next(); wr(0, 5, 32'hDEADBEEF, 1'b0); sb_set = 1'b1; sb_idx = 5'd6; rd(5, 6);
        next(); rd(5, 6);
        @(negedge clk);
        chk("x5_before_rst", rd_dat_n[31:0], 32'hDEADBEEF);
        chk("x6_busy_before", 32'(rd_busy_b[1]), 32'h1);
        next(); rd(5, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dat", rd_dat_b[31:0], 32'h0);
        chk("rst_mid_busy", 32'(rd_busy_b), 32'h0);
        chk("rst_mid_any", 32'(any_b | any_n), 32'h0);
        next(); rst_n = 1'b1; rd(5, 6);
        @(negedge clk);
        chk("post_rst_dat", rd_dat_n[31:0], 32'h0);
        chk("model_rst", model_regs[5], 32'h0);
        next();
        @(negedge clk);
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_ex_regfile_mp.md
Name: core_ex_regfile_mp

Overview:
Parametrised multi-port integer register file for the execute stage. It provides NRD read ports and NWR write-back ports, with optional same-cycle write-to-read bypass. A per-register scoreboard (busy bits) tracks pending long-latency results so issue logic can stall on RAW hazards. Register x0 reads as zero, ignores writes and is never busy.

Parameters:
XLEN, 32, data width of each register
RF_NUM, 32, number of architectural registers (power of two, >=2)
RFIDX_W, 5, index width, equal to log2(RF_NUM)
NRD, 2, number of read ports (1..4)
NWR, 1, number of write-back ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return registered state only

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_idx  in  NRD*RFIDX_W  read indices; port k occupies bits [k*RFIDX_W +: RFIDX_W]
rd_dat  out  NRD*XLEN  read data; port k occupies [k*XLEN +: XLEN]
rd_busy  out  NRD  port k register has a pending (scoreboarded) write
wb_wen  in  NWR  write enable per write port
wb_idx  in  NWR*RFIDX_W  write index per port
wb_dat  in  NWR*XLEN  write data per port
wb_clr  in  NWR  this write retires a scoreboarded op; clears its busy bit
sb_set  in  1  mark register sb_idx busy (long-latency op issued)
sb_idx  in  RFIDX_W  register to mark busy
sb_busy_any  out  1  OR of all busy bits (pipeline drain / flush check)

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0 and all busy bits = 0. Consequently rd_dat = 0, rd_busy = 0 and sb_busy_any = 0 during reset and on the first cycle after it. Deassertion is synchronised elsewhere.
- Write: on the rising edge, reg[wb_idx[p]] <= wb_dat[p] when wb_wen[p]=1 and wb_idx[p] != 0.
- Write/write conflict (same idx, both ports enabled): the highest-numbered port wins. No error is flagged.
- Read is combinational: rd_dat[k] = reg[rd_idx[k]], and is 0 when rd_idx[k] = 0.
- Bypass when BYPASS=1: if any port p has wb_wen[p]=1 and wb_idx[p]=rd_idx[k]!=0, then rd_dat[k] = wb_dat of the highest such p, in the same cycle.
- No bypass when BYPASS=0: the new value is visible one cycle after the write edge.
- Scoreboard updates on the rising edge:
  - busy[sb_idx] <= 1 when sb_set=1 and sb_idx != 0.
  - busy[wb_idx[p]] <= 0 when wb_wen[p]=1 and wb_clr[p]=1.
  - wb_clr with wb_wen=0 is ignored.
- Set and clear of the same idx in the same cycle: set wins, so busy stays 1 (a new producer was issued). Clear and set of different indices apply independently.
- busy[0] is constant 0.
- rd_busy[k]:
  - BYPASS=1: busy[rd_idx[k]] AND NOT (some port p has wb_wen[p] & wb_clr[p] & wb_idx[p]==rd_idx[k] this cycle). The value being retired is forwarded, so it is not a hazard.
  - BYPASS=0: busy[rd_idx[k]] only.
- sb_busy_any = |busy, registered state only.
- Reset asserted mid-operation: state clears immediately. Any writes or sets in that cycle are lost.
- Latency summary: read 0 cycles; write visible next cycle (0 cycles with bypass); scoreboard set/clear visible next cycle.
- Storage uses per-register enabled flops; no SRAM macro.

Test Plan:
1. Reset: drive rst_n=0 mid-run after writing x5=0xDEADBEEF -> rd_dat for idx 5 = 0 immediately; all rd_busy = 0 and sb_busy_any = 0.
2. Basic write/read: write x3=0x12345678 on port 0 -> next cycle rd_idx0=3 gives 0x12345678. Write x0=0xFFFFFFFF -> rd_idx=0 gives 0.
3. Bypass: BYPASS=1, write x7=0xA5A5A5A5 while rd_idx1=7 -> rd_dat1=0xA5A5A5A5 in the same cycle. BYPASS=0 -> old value this cycle, new value next cycle.
4. Write conflict: NWR=2, port0 x9=0x1111 and port1 x9=0x2222 in the same cycle -> x9 reads 0x2222; the bypass path also shows 0x2222.
5. Scoreboard:
   - sb_set idx 4 -> next cycle rd_busy=1 for rd_idx=4, sb_busy_any=1.
   - wb x4 with wb_clr=1 -> that cycle rd_busy=0 (BYPASS=1); next cycle busy=0 and sb_busy_any=0.
6. Set/clear collision: busy[4]=1, then same cycle sb_set idx 4 plus wb x4 with wb_clr=1 -> busy[4] remains 1 next cycle and the x4 data is updated. sb_set idx 0 -> no change.
